// File: rtl/num_detector.sv
// num_detector: registered 5-bit number classifier driving five property LEDs
module num_detector (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] number,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4,
  output logic       LED5
);
  // Each mask has bit n set when value n has the property
  localparam logic [31:0] PRIME  = 32'hA08A_28AC;
  localparam logic [31:0] DIV3   = 32'h4924_9249;
  localparam logic [31:0] POW2   = 32'h0001_0116;
  localparam logic [31:0] FIB    = 32'h0020_212F;
  localparam logic [31:0] SQUARE = 32'h0201_0213;
  logic [4:0] flags;
  always_comb flags = {PRIME[number], DIV3[number], POW2[number], FIB[number], SQUARE[number]};
  always_ff @(posedge clk)
    {LED1, LED2, LED3, LED4, LED5} <= rst ? 5'b0 : flags;
endmodule

// File: tb/tb_num_detector.sv
// tb_num_detector: random and directed checks of num_detector against an arithmetic model
module tb_num_detector;
  logic clk = 0, rst = 1;
  logic [4:0] number = 0;
  logic LED1, LED2, LED3, LED4, LED5;
  int errors = 0, checks = 0;
  wire [4:0] leds = {LED1, LED2, LED3, LED4, LED5};

  num_detector dut (.clk(clk), .rst(rst), .number(number),
    .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4), .LED5(LED5));

  always #5 clk = ~clk;

  function automatic bit is_prime(int n);
    if (n < 2) return 0;
    for (int d = 2; d < n; d++) if (n % d == 0) return 0;
    return 1;
  endfunction

  function automatic bit is_fib(int n);
    int a = 0, b = 1, t;
    while (a <= 31) begin
      if (a == n) return 1;
      t = a + b; a = b; b = t;
    end
    return 0;
  endfunction

  function automatic bit is_square(int n);
    for (int i = 0; i * i <= n; i++) if (i * i == n) return 1;
    return 0;
  endfunction

  function automatic bit is_pow2(int n);
    for (int p = 1; p <= 31; p = p * 2) if (p == n) return 1;
    return 0;
  endfunction

  function automatic logic [4:0] model(int n);
    return {is_prime(n), n % 3 == 0, is_pow2(n), is_fib(n), is_square(n)};
  endfunction

  task automatic step(input int n, input logic r);
    @(negedge clk);
    number = 5'(n);
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      step(5, 1);
      checks++;
      if (leds !== 5'b0) begin errors++; $display("FAIL reset cyc%0d got=%b want=00000", i, leds); end
    end
    step(5, 0);
    checks++;
    if (leds !== 5'b10010) begin errors++; $display("FAIL reset_release got=%b want=10010", leds); end
  endtask

  task automatic test_directed;
    int vals[7] = '{0, 1, 3, 16, 21, 25, 31};
    logic [4:0] want[7] = '{5'b01011, 5'b00111, 5'b11010, 5'b00101, 5'b01010, 5'b00001, 5'b10000};
    foreach (vals[i]) begin
      step(vals[i], 0);
      checks++;
      if (leds !== want[i]) begin errors++; $display("FAIL directed n=%0d got=%b want=%b", vals[i], leds, want[i]); end
    end
  endtask

  task automatic test_sweep;
    int cnt[5] = '{0, 0, 0, 0, 0};
    int want_cnt[5] = '{11, 11, 5, 8, 6};
    for (int n = 0; n < 32; n++) begin
      step(n, 0);
      checks++;
      if (leds !== model(n)) begin errors++; $display("FAIL sweep n=%0d got=%b want=%b", n, leds, model(n)); end
      for (int k = 0; k < 5; k++) cnt[k] += int'(leds[4-k]);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (cnt[k] !== want_cnt[k]) begin errors++; $display("FAIL sweep_total LED%0d got=%0d want=%0d", k + 1, cnt[k], want_cnt[k]); end
    end
  endtask

  task automatic test_latency;
    step(7, 0);
    #2 number = 8;
    #1;
    checks++;
    if (leds !== 5'b10000) begin errors++; $display("FAIL latency_hold got=%b want=10000", leds); end
    @(posedge clk);
    #1;
    checks++;
    if (leds !== 5'b00110) begin errors++; $display("FAIL latency_update got=%b want=00110", leds); end
  endtask

  task automatic test_reset_mid;
    for (int n = 10; n < 17; n++) begin
      step(n, n == 13);
      checks++;
      if (leds !== (n == 13 ? 5'b0 : model(n)))
        begin errors++; $display("FAIL reset_mid n=%0d got=%b want=%b", n, leds, n == 13 ? 5'b0 : model(n)); end
    end
  endtask

  task automatic test_random;
    int n;
    logic r;
    for (int i = 0; i < 200; i++) begin
      n = int'($urandom_range(31));
      r = ($urandom_range(15) == 0);
      step(n, r);
      checks++;
      if (leds !== (r ? 5'b0 : model(n)))
        begin errors++; $display("FAIL random n=%0d rst=%b got=%b want=%b", n, r, leds, r ? 5'b0 : model(n)); end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    for (int i = 0; i < 3; i++) begin
      n = int'($urandom_range(31));
      step(n, 0);
      step(n, 0);
      checks++;
      if (leds !== model(n)) begin errors++; $display("FAIL hold n=%0d got=%b want=%b", n, leds, model(n)); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_sweep;
    test_latency;
    test_reset_mid;
    test_random;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
